// File: rtl/udp_tx_frame_arbiter.sv
// udp_tx_frame_arbiter
//
// Round-robin frame arbiter in front of the UDP stack transmit side. PORTS
// local requesters compete for the single header/payload interface. A winner
// keeps the grant for a whole frame: its header is registered and offered
// downstream, then its payload is passed through combinationally until the
// tlast beat completes. The search for the next winner starts one past the
// requester that last completed a frame.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   s_udp_hdr_valid/ready            per-requester header handshake
//   s_udp_ip_dest_ip                 PORTS x 32 destination IP
//   s_udp_source_port/dest_port/length  PORTS x 16 UDP header fields
//   s_udp_payload_axis_*             per-requester payload stream
//   m_udp_hdr_valid/ready            header handshake to the UDP stack
//   m_udp_ip_dest_ip, m_udp_*_port, m_udp_length  registered header fields
//   m_udp_payload_axis_*             payload stream of the granted requester
//   status_busy                      a frame is in flight
//   status_grant                     current or most recent grant index
//   status_frame_count               completed frames, wraps at 16 bits
module udp_tx_frame_arbiter #(
  parameter int PORTS      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) >> 3,
  parameter int GW         = $clog2(PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS-1:0]            s_udp_hdr_valid,
  output logic [PORTS-1:0]            s_udp_hdr_ready,
  input  logic [PORTS*32-1:0]         s_udp_ip_dest_ip,
  input  logic [PORTS*16-1:0]         s_udp_source_port,
  input  logic [PORTS*16-1:0]         s_udp_dest_port,
  input  logic [PORTS*16-1:0]         s_udp_length,
  input  logic [PORTS*DATA_WIDTH-1:0] s_udp_payload_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0] s_udp_payload_axis_tkeep,
  input  logic [PORTS-1:0]            s_udp_payload_axis_tvalid,
  output logic [PORTS-1:0]            s_udp_payload_axis_tready,
  input  logic [PORTS-1:0]            s_udp_payload_axis_tlast,
  input  logic [PORTS-1:0]            s_udp_payload_axis_tuser,
  output logic                        m_udp_hdr_valid,
  input  logic                        m_udp_hdr_ready,
  output logic [31:0]                 m_udp_ip_dest_ip,
  output logic [15:0]                 m_udp_source_port,
  output logic [15:0]                 m_udp_dest_port,
  output logic [15:0]                 m_udp_length,
  output logic [DATA_WIDTH-1:0]       m_udp_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0]       m_udp_payload_axis_tkeep,
  output logic                        m_udp_payload_axis_tvalid,
  input  logic                        m_udp_payload_axis_tready,
  output logic                        m_udp_payload_axis_tlast,
  output logic                        m_udp_payload_axis_tuser,
  output logic                        status_busy,
  output logic [GW-1:0]               status_grant,
  output logic [15:0]                 status_frame_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic [15:0]   frame_cnt_q;

  logic [GW-1:0] sel;
  logic          sel_found;
  int            scan_idx;

  logic          hdr_take;
  logic          hdr_done;
  logic          frame_done;

  logic          vld_p0;
  logic [31:0]   hdr_ip_p0;
  logic [15:0]   hdr_sport_p0;
  logic [15:0]   hdr_dport_p0;
  logic [15:0]   hdr_len_p0;

  function automatic logic [15:0] cnt_wrap_inc(input logic [15:0] v);
    return v + 16'd1;
  endfunction

  // Rotating-priority search: first valid requester after last_grant, with wrap.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    scan_idx  = 0;
    for (int k = 1; k <= PORTS; k++) begin
      scan_idx = (int'(last_grant_q) + k) % PORTS;
      if (!sel_found && s_udp_hdr_valid[scan_idx]) begin
        sel       = scan_idx[GW-1:0];
        sel_found = 1'b1;
      end
    end
  end

  // Payload pass-through; everything is held at zero outside PAYLOAD.
  always_comb begin
    m_udp_payload_axis_tdata  = '0;
    m_udp_payload_axis_tkeep  = '0;
    m_udp_payload_axis_tvalid = 1'b0;
    m_udp_payload_axis_tlast  = 1'b0;
    m_udp_payload_axis_tuser  = 1'b0;
    s_udp_payload_axis_tready = '0;
    if (state_q == PAYLOAD) begin
      m_udp_payload_axis_tdata  = s_udp_payload_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
      m_udp_payload_axis_tkeep  = s_udp_payload_axis_tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH];
      m_udp_payload_axis_tvalid = s_udp_payload_axis_tvalid[grant_q];
      m_udp_payload_axis_tlast  = s_udp_payload_axis_tlast[grant_q];
      m_udp_payload_axis_tuser  = s_udp_payload_axis_tuser[grant_q];
      s_udp_payload_axis_tready[grant_q] = m_udp_payload_axis_tready;
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    hdr_take        = 1'b0;
    hdr_done        = 1'b0;
    frame_done      = 1'b0;
    s_udp_hdr_ready = '0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          // Gated by rst_n so no header is acknowledged while reset is held.
          s_udp_hdr_ready[sel] = rst_n;
          hdr_take             = 1'b1;
          grant_d              = sel;
          state_d              = HDR;
        end
      end
      HDR: begin
        if (m_udp_hdr_ready) begin
          hdr_done = 1'b1;
          state_d  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (m_udp_payload_axis_tvalid && m_udp_payload_axis_tready && m_udp_payload_axis_tlast) begin
          frame_done   = 1'b1;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(PORTS - 1);
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      if (frame_done) begin
        frame_cnt_q <= cnt_wrap_inc(frame_cnt_q);
      end
    end
  end

  // Stage p0: header captured from the winning requester, held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0       <= 1'b0;
      hdr_ip_p0    <= '0;
      hdr_sport_p0 <= '0;
      hdr_dport_p0 <= '0;
      hdr_len_p0   <= '0;
    end else if (hdr_take) begin
      vld_p0       <= 1'b1;
      hdr_ip_p0    <= s_udp_ip_dest_ip[int'(sel)*32 +: 32];
      hdr_sport_p0 <= s_udp_source_port[int'(sel)*16 +: 16];
      hdr_dport_p0 <= s_udp_dest_port[int'(sel)*16 +: 16];
      hdr_len_p0   <= s_udp_length[int'(sel)*16 +: 16];
    end else if (hdr_done) begin
      vld_p0       <= 1'b0;
    end
  end

  assign m_udp_hdr_valid    = vld_p0;
  assign m_udp_ip_dest_ip   = hdr_ip_p0;
  assign m_udp_source_port  = hdr_sport_p0;
  assign m_udp_dest_port    = hdr_dport_p0;
  assign m_udp_length       = hdr_len_p0;

  assign status_busy        = (state_q != IDLE);
  assign status_grant       = grant_q;
  assign status_frame_count = frame_cnt_q;

endmodule
